// File: rtl/jedro_1_wb_if.sv
// jedro_1_wb_if: issue, result-source, regfile-write and hazard-query signals of the write-back unit.
interface jedro_1_wb_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_SRC        = 2
);
  logic                               issue_valid;
  logic [REG_ADDR_WIDTH-1:0]          issue_addr;
  logic                               issue_ready;
  logic [NUM_SRC-1:0]                 src_valid;
  logic [NUM_SRC-1:0]                 src_ready;
  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]  src_addr;
  logic [NUM_SRC*DATA_WIDTH-1:0]      src_data;
  logic                               rf_we;
  logic [REG_ADDR_WIDTH-1:0]          rf_addr;
  logic [DATA_WIDTH-1:0]              rf_data;
  logic [REG_ADDR_WIDTH-1:0]          rd_addr_a;
  logic [REG_ADDR_WIDTH-1:0]          rd_addr_b;
  logic                               hazard_a;
  logic                               hazard_b;
  logic [DATA_WIDTH-1:0]              fwd_a;
  logic [DATA_WIDTH-1:0]              fwd_b;
  logic                               err;
  modport master (
    output issue_valid, issue_addr, src_valid, src_addr, src_data, rd_addr_a, rd_addr_b,
    input  issue_ready, src_ready, rf_we, rf_addr, rf_data, hazard_a, hazard_b, fwd_a, fwd_b, err
  );
  modport slave (
    input  issue_valid, issue_addr, src_valid, src_addr, src_data, rd_addr_a, rd_addr_b,
    output issue_ready, src_ready, rf_we, rf_addr, rf_data, hazard_a, hazard_b, fwd_a, fwd_b, err
  );
endinterface

// File: rtl/jedro_1_wb_unit.sv
// jedro_1_wb_unit: round-robin write-back arbiter with per-register RAW scoreboard; JEDRO_1_WB_FWD_EN enables regfile-write forwarding.
module jedro_1_wb_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int NUM_SRC         = 2,
  parameter int MAX_OUTSTANDING = 3
) (
  input logic          clk_i,
  input logic          rst_i,
  jedro_1_wb_if.slave  bus
);
  localparam int NREG  = 2**REG_ADDR_WIDTH;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int PTR_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W:0]   NSRC    = (PTR_W+1)'(NUM_SRC);
  logic [CNT_W-1:0]          cnt [NREG];
  logic [NREG-1:0]           inc, dec;
  logic [PTR_W-1:0]          ptr, gnt_idx;
  logic [PTR_W:0]            j;
  logic                      any_valid, issue_fire;
  logic [REG_ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0]     gnt_data;

  assign bus.issue_ready = bus.issue_addr == '0 || cnt[bus.issue_addr] != CNT_MAX;
  assign issue_fire      = bus.issue_valid && bus.issue_ready;
  assign any_valid       = |bus.src_valid;

  // Walk candidates farthest-first so the nearest valid source after ptr wins.
  always_comb begin
    gnt_idx = ptr;
    j = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      j = {1'b0, ptr} + (PTR_W+1)'(i);
      j = j >= NSRC ? j - NSRC : j;
      if (bus.src_valid[j[PTR_W-1:0]]) gnt_idx = j[PTR_W-1:0];
    end
  end

  assign gnt_addr      = bus.src_addr[gnt_idx*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
  assign gnt_data      = bus.src_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign bus.src_ready = any_valid ? NUM_SRC'(1) << gnt_idx : '0;

  always_ff @(posedge clk_i)
    if (rst_i) begin
      ptr         <= PTR_W'(NUM_SRC-1);
      bus.rf_we   <= 1'b0;
      bus.rf_addr <= '0;
      bus.rf_data <= '0;
      bus.err     <= 1'b0;
    end else begin
      bus.rf_we <= any_valid && gnt_addr != '0;
      if (any_valid) begin
        ptr         <= gnt_idx;
        bus.rf_addr <= gnt_addr;
        bus.rf_data <= gnt_data;
      end
      if (bus.rf_we && cnt[bus.rf_addr] == '0) bus.err <= 1'b1;
    end

  // Retire is the cycle rf_we is high, so the hazard clears once the regfile holds the value.
  always_comb begin
    inc = '0;
    dec = '0;
    if (issue_fire && bus.issue_addr != '0) inc[bus.issue_addr] = 1'b1;
    if (bus.rf_we) dec[bus.rf_addr] = 1'b1;
  end

  always_ff @(posedge clk_i)
    for (int r = 0; r < NREG; r++)
      if (rst_i) cnt[r] <= '0;
      else if (inc[r] && !dec[r]) cnt[r] <= cnt[r] + CNT_W'(1);
      else if (dec[r] && !inc[r] && cnt[r] != '0) cnt[r] <= cnt[r] - CNT_W'(1);

`ifdef JEDRO_1_WB_FWD_EN
  logic byp_a, byp_b;
  assign byp_a = bus.rf_we && bus.rf_addr == bus.rd_addr_a && cnt[bus.rd_addr_a] == CNT_W'(1);
  assign byp_b = bus.rf_we && bus.rf_addr == bus.rd_addr_b && cnt[bus.rd_addr_b] == CNT_W'(1);
  assign bus.hazard_a = bus.rd_addr_a != '0 && cnt[bus.rd_addr_a] != '0 && !byp_a;
  assign bus.hazard_b = bus.rd_addr_b != '0 && cnt[bus.rd_addr_b] != '0 && !byp_b;
  assign bus.fwd_a    = byp_a ? bus.rf_data : '0;
  assign bus.fwd_b    = byp_b ? bus.rf_data : '0;
`else
  assign bus.hazard_a = bus.rd_addr_a != '0 && cnt[bus.rd_addr_a] != '0;
  assign bus.hazard_b = bus.rd_addr_b != '0 && cnt[bus.rd_addr_b] != '0;
  assign bus.fwd_a    = '0;
  assign bus.fwd_b    = '0;
`endif
endmodule

// File: doc/jedro_1_wb_unit.md
Name: jedro_1_wb_unit

Overview:
Parametrised write-back stage for the jedro_1 core. It arbitrates register-file writes from NUM_SRC result producers (ALU, LSU, future units) with round-robin valid/ready handshakes. It tracks outstanding destination writes in a per-register scoreboard so the decoder can detect RAW hazards. It sits between the execute units and jedro_1_regfile's write port and replaces the direct ALU-to-regfile connection.

Parameters:
DATA_WIDTH, 32, register data width
REG_ADDR_WIDTH, 5, register address width (2**REG_ADDR_WIDTH registers, x0 hardwired zero)
NUM_SRC, 2, number of result sources (>=1); index 0 = ALU, 1 = LSU
MAX_OUTSTANDING, 3, max in-flight writes per register; counter width CNT_W = $clog2(MAX_OUTSTANDING+1)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
issue_valid_i  in  1  decoder issues an instruction writing issue_addr_i
issue_addr_i  in  REG_ADDR_WIDTH  destination of issued instruction
issue_ready_o  out  1  issue may be accepted (scoreboard not saturated)
src_valid_i  in  NUM_SRC  per-source result valid
src_ready_o  out  NUM_SRC  per-source grant, one-hot or zero
src_addr_i  in  NUM_SRC*REG_ADDR_WIDTH  packed destination addresses, source k at [k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
src_data_i  in  NUM_SRC*DATA_WIDTH  packed result data, same packing
rf_we_o  out  1  regfile write enable (registered)
rf_addr_o  out  REG_ADDR_WIDTH  regfile write address (registered)
rf_data_o  out  DATA_WIDTH  regfile write data (registered)
rd_addr_a_i, rd_addr_b_i  in  REG_ADDR_WIDTH each  decoder source-register addresses
hazard_a_o, hazard_b_o  out  1 each  operand not yet available (combinational)
fwd_a_o, fwd_b_o  out  DATA_WIDTH each  forwarded operand data (see Optional Feature)
err_o  out  1  sticky: write retired to a register with zero pending count

Behaviour:
- Clock clk_i; reset rst_i is synchronous and active-high. Reset: all counters 0, RR pointer = NUM_SRC-1 (source 0 wins first), rf_we_o=0, rf_addr_o=0, rf_data_o=0, err_o=0. Reset mid-transfer discards the pending write.
- Issue handshake: fire when issue_valid_i && issue_ready_o. issue_ready_o = (issue_addr_i==0) || cnt[issue_addr_i] != MAX_OUTSTANDING. Issue to x0 never changes counters.
- Arbitration: combinational round-robin. Grant the first valid source after the RR pointer, wrapping modulo NUM_SRC. src_ready_o is that one-hot grant. The pointer updates to the granted index on a grant; otherwise it holds. At most one handshake per cycle. src_ready_o depends on src_valid_i; sources must not make valid depend on ready.
- Write register: on a handshake, next cycle rf_we_o=1 (0 if address is x0), and rf_addr_o/rf_data_o take the granted source's values. Without a handshake, rf_we_o=0 and addr/data hold. Latency: 1 cycle from handshake to rf_we_o.
- Retire: counter decrement happens at the clock edge ending a cycle with rf_we_o=1, so the regfile holds the new value when the hazard drops. If the count is already 0, the counter stays 0 and err_o is set until reset.
- Issue and retire on the same register in the same cycle: the count is unchanged. Counters never wrap.
- Hazard: hazard_x_o = (rd_addr_x_i != 0) && cnt[rd_addr_x_i] != 0. Forwarding may modify this (see Optional Feature).

Optional Feature:
Macro JEDRO_1_WB_FWD_EN.
- Defined: if rf_we_o && rf_addr_o==rd_addr_x_i && cnt[rd_addr_x_i]==1, then hazard_x_o=0 and fwd_x_o=rf_data_o. This saves one stall cycle. Otherwise fwd_x_o=0.
- Not defined: fwd_a_o=fwd_b_o=0 constantly, and the hazard follows the base rule only.

Test Plan:
- Reset then issue x5 -> next cycle hazard_a_o=1 for rd_addr_a_i=5. Source 0 writes x5=0xDEADBEEF -> rf_we_o=1, rf_addr_o=5, rf_data_o=0xDEADBEEF one cycle later. Hazard drops the following cycle, or during the rf_we_o cycle with JEDRO_1_WB_FWD_EN, where fwd_a_o=0xDEADBEEF.
- Both sources valid continuously from reset (NUM_SRC=2) -> grants alternate 0,1,0,1. Each result appears once on rf_*_o in grant order.
- Issue x7 three times (MAX_OUTSTANDING=3) -> issue_ready_o=0 for x7 while x3 stays ready. Retire one x7 -> issue_ready_o returns to 1 the next cycle.
- Same-cycle issue and retire on x7 with count 1 -> count stays 1 and hazard stays 1.
- Source writes x0=0x1234 -> src_ready_o=1, rf_we_o stays 0, no counter change. Write to x9 with count 0 -> err_o=1 and held until rst_i.
- Assert rst_i while a write is in flight -> next cycle rf_we_o=0, all hazards 0, issue_ready_o=1.
